// File: rtl/ahb_sram_slave_pkg.sv
// Shared bus widths, AHB encodings, FSM states and byte-lane helper for the AHB SRAM slave.
// The optional wait-state feature is selected with AHB_SLV_WAIT_EN.
`ifndef HADDR_BUS
`define HADDR_BUS [31:0]
`endif
`ifndef HDATA_BUS
`define HDATA_BUS [31:0]
`endif

package ahb_sram_slave_pkg;

   typedef enum logic [1:0] {
      HTransIdle   = 2'b00,
      HTransBusy   = 2'b01,
      HTransNonseq = 2'b10,
      HTransSeq    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSizeByte = 3'b000;
   localparam logic [2:0] HSizeHalf = 3'b001;
   localparam logic [2:0] HSizeWord = 3'b010;

   localparam logic HRespOkay  = 1'b0;
   localparam logic HRespError = 1'b1;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWait = 3'd1,
      StData = 3'd2,
      StErr1 = 3'd3,
      StErr2 = 3'd4
   } state_e;

   // Little-endian byte enables; callers only pass aligned transfers.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b1111;
      if (size == HSizeByte) begin
         mask = 4'b0001 << lane;
      end else if (size == HSizeHalf) begin
         mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      return mask;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_bytemem.sv
// Word-organised storage with per-byte write enables, combinational read and synchronous write.
// Contents are deliberately not reset.
module ahb_sram_bytemem #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = 12
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Out-of-range reads only happen for transfers that are answered with ERROR.
   assign rdata_o = ({1'b0, raddr_i} < (AW+1)'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single outstanding transfer, two-cycle ERROR response, write forwarding.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES data-phase wait states per OKAY transfer.
`ifndef HADDR_BUS
`define HADDR_BUS [31:0]
`endif
`ifndef HDATA_BUS
`define HDATA_BUS [31:0]
`endif

module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int unsigned DEPTH       = 4096,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slv_hsel_i,
   input  logic [1:0]       slv_htrans_i,
   input  logic `HADDR_BUS  slv_haddr_i,
   input  logic             slv_hwrite_i,
   input  logic [2:0]       slv_hsize_i,
   input  logic `HDATA_BUS  slv_hwdata_i,
   input  logic             slv_hready_i,
   output logic             slv_hreadyout_o,
   output logic             slv_hresp_o,
   output logic `HDATA_BUS  slv_hrdata_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WAIT_CYCLES > 7) begin : g_wait_range
      $error("WAIT_CYCLES must be in 0..7");
   end

   state_e        state_q, state_d;
   logic [31:0]   hrdata_q, hrdata_d;
   logic [AW-1:0] waddr_q;
   logic [1:0]    lane_q;
   logic [2:0]    size_q;
   logic          write_q;

   logic          accept, xfer_err, misalign, out_of_range;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   be_bits, mem_rdata, fwd_word;
   logic [AW-1:0] raddr;

   assign raddr        = slv_haddr_i[AW+1:2];
   assign accept       = (state_q inside {StIdle, StData, StErr2}) & slv_hsel_i & slv_hready_i
                         & ((slv_htrans_i == HTransNonseq) | (slv_htrans_i == HTransSeq));
   assign out_of_range = {2'b00, slv_haddr_i[31:2]} >= 32'(DEPTH);
   assign misalign     = ((slv_hsize_i == HSizeHalf) & slv_haddr_i[0])
                         | ((slv_hsize_i == HSizeWord) & (slv_haddr_i[1:0] != 2'b00));
   assign xfer_err     = out_of_range | (slv_hsize_i > HSizeWord) | misalign;

   assign mem_we = (state_q == StData) & write_q;
   assign mem_be = lane_mask(size_q, lane_q);

   always_comb begin
      be_bits = '0;
      for (int b = 0; b < 4; b++) begin
         be_bits[8*b +: 8] = {8{mem_be[b]}};
      end
   end

   // A read accepted while a write to the same word commits sees the merged word.
   assign fwd_word = (mem_we && (waddr_q == raddr))
                     ? ((mem_rdata & ~be_bits) | (slv_hwdata_i & be_bits)) : mem_rdata;

   ahb_sram_bytemem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .be_i    (mem_be),
      .waddr_i (waddr_q),
      .wdata_i (slv_hwdata_i),
      .raddr_i (raddr),
      .rdata_o (mem_rdata)
   );

`ifdef AHB_SLV_WAIT_EN
   logic [2:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      hrdata_d = hrdata_q;
`ifdef AHB_SLV_WAIT_EN
      cnt_d    = cnt_q;
`endif
      unique case (state_q)
         StIdle, StData, StErr2: begin
            if (!accept) begin
               state_d = StIdle;
            end else if (xfer_err) begin
               state_d  = StErr1;
               hrdata_d = '0;
            end else begin
               hrdata_d = slv_hwrite_i ? '0 : fwd_word;
`ifdef AHB_SLV_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
                  cnt_d   = 3'(WAIT_CYCLES - 1);
               end else begin
                  state_d = StData;
               end
`else
               state_d = StData;
`endif
            end
         end
`ifdef AHB_SLV_WAIT_EN
         StWait: begin
            if (cnt_q == 3'd0) begin
               state_d = StData;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
`endif
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         hrdata_q <= '0;
         waddr_q  <= '0;
         lane_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hrdata_q <= hrdata_d;
         if (accept) begin
            waddr_q <= raddr;
            lane_q  <= slv_haddr_i[1:0];
            size_q  <= slv_hsize_i;
            write_q <= slv_hwrite_i;
         end
      end
   end

`ifdef AHB_SLV_WAIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign slv_hreadyout_o = !(state_q inside {StWait, StErr1});
   assign slv_hresp_o     = (state_q inside {StErr1, StErr2}) ? HRespError : HRespOkay;
   assign slv_hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed and random AHB transfers against a transaction-level model.
// Expected wait states follow AHB_SLV_WAIT_EN (WAIT_CYCLES=3 when enabled, none otherwise).
`ifndef HADDR_BUS
`define HADDR_BUS [31:0]
`endif
`ifndef HDATA_BUS
`define HDATA_BUS [31:0]
`endif

module tb_ahb_sram_slave;

   localparam int unsigned DEPTH       = 4096;
   localparam int unsigned WAIT_CYCLES = 3;
`ifdef AHB_SLV_WAIT_EN
   localparam int unsigned ExpWaits = WAIT_CYCLES;
`else
   localparam int unsigned ExpWaits = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hsel = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b000;
   logic [31:0] hwdata = '0;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign hready = hreadyout;

   ahb_sram_slave #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .slv_hsel_i      (hsel),
      .slv_htrans_i    (htrans),
      .slv_haddr_i     (haddr),
      .slv_hwrite_i    (hwrite),
      .slv_hsize_i     (hsize),
      .slv_hwdata_i    (hwdata),
      .slv_hready_i    (hready),
      .slv_hreadyout_o (hreadyout),
      .slv_hresp_o     (hresp),
      .slv_hrdata_o    (hrdata)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } xfer_t;

   logic [31:0] ref_mem [DEPTH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                input logic write, input logic [2:0] size,
                                input logic [31:0] wdata);
      xfer_t t;
      t.sel = sel; t.trans = trans; t.addr = addr; t.write = write;
      t.size = size; t.wdata = wdata; t.chk = 1'b0; t.exp = '0;
      return t;
   endfunction

   function automatic xfer_t rd_chk(input logic [31:0] addr, input logic [31:0] exp);
      xfer_t t;
      t = mk(1'b1, 2'b10, addr, 1'b0, 3'b010, '0);
      t.chk = 1'b1;
      t.exp = exp;
      return t;
   endfunction

   function automatic bit is_live(input xfer_t t);
      return t.sel && t.trans[1];
   endfunction

   function automatic bit is_err(input xfer_t t);
      int unsigned word;
      word = 32'(t.addr[31:2]);
      if (word >= DEPTH) return 1'b1;
      if (t.size > 3'd2) return 1'b1;
      if (t.size == 3'd1 && t.addr[0]) return 1'b1;
      if (t.size == 3'd2 && t.addr[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void ref_write(input xfer_t t);
      int unsigned word, base, n;
      word = 32'(t.addr[31:2]);
      base = 32'(t.addr[1:0]);
      n    = 1 << t.size;
      for (int b = 0; b < 4; b++) begin
         if (b >= base && b < base + n) ref_mem[word][8*b +: 8] = t.wdata[8*b +: 8];
      end
   endfunction

   task automatic drive(input xfer_t cur, input xfer_t dp);
      hsel   = cur.sel;
      htrans = cur.trans;
      haddr  = cur.addr;
      hwrite = cur.write;
      hsize  = cur.size;
      hwdata = dp.write ? dp.wdata : $urandom();
   endtask

   task automatic finish_dp(input xfer_t dp, input int waits);
      bit live, err;
      live = is_live(dp);
      err  = live && is_err(dp);
      check_eq("waits", 32'(waits), live ? (err ? 32'd1 : 32'(ExpWaits)) : 32'd0);
      check_eq("hresp", {31'd0, hresp}, {31'd0, err});
      if (err) begin
         check_eq("err_rdata", hrdata, 32'd0);
      end else if (live && !dp.write) begin
         check_eq("rdata", hrdata, ref_mem[32'(dp.addr[31:2])]);
      end
      if (dp.chk) check_eq("directed", hrdata, dp.exp);
      if (live && !err && dp.write) ref_write(dp);
   endtask

   // Pipelined master: address phase of cur overlaps the data phase of dp.
   task automatic run_xfers(input xfer_t seq[$]);
      xfer_t cur, dp;
      int    waits;
      bit    rdy;
      dp    = mk(1'b0, 2'b00, '0, 1'b0, 3'b000, '0);
      cur   = seq.size() > 0 ? seq.pop_front() : dp;
      drive(cur, dp);
      waits = 0;
      rdy   = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy) begin
            dp    = cur;
            cur   = seq.size() > 0 ? seq.pop_front() : mk(1'b0, 2'b00, '0, 1'b0, 3'b000, '0);
            drive(cur, dp);
            waits = 0;
         end
         @(negedge clk);
         rdy = hreadyout;
         if (!rdy) begin
            waits++;
            check_eq("wait_hresp", {31'd0, hresp}, {31'd0, is_live(dp) && is_err(dp)});
            if (waits > int'(ExpWaits) + 1) begin
               check_eq("wait_bound", 32'(waits), 32'(ExpWaits));
               return;
            end
         end else begin
            finish_dp(dp, waits);
            if (!is_live(cur) && seq.size() == 0) return;
         end
      end
   endtask

   task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] old_word);
      xfer_t q[$];
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b1; hsize = 3'b010;
      @(posedge clk);
      #1;
      htrans = 2'b00; hsel = 1'b0; hwdata = ~old_word;
      @(negedge clk);
      check_eq("pre_rst_ready", {31'd0, hreadyout}, {31'd0, ExpWaits == 0});
      rst_n = 1'b0;
      #1;
      check_eq("rst_ready", {31'd0, hreadyout}, 32'd1);
      check_eq("rst_resp", {31'd0, hresp}, 32'd0);
      check_eq("rst_rdata", hrdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back(rd_chk(addr, old_word));
      run_xfers(q);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      xfer_t q[$];
      xfer_t t;
      int    r;
      int unsigned word, lane;

      #2;
      check_eq("reset_ready", {31'd0, hreadyout}, 32'd1);
      check_eq("reset_resp", {31'd0, hresp}, 32'd0);
      check_eq("reset_rdata", hrdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back write then read of the same word.
      q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF));
      q.push_back(rd_chk(32'h10, 32'hDEADBEEF));
      run_xfers(q);

      // Byte lane update over an existing word.
      q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'h11223344));
      q.push_back(mk(1'b1, 2'b11, 32'h13, 1'b1, 3'b000, 32'hAA5A5A5A));
      q.push_back(rd_chk(32'h10, 32'hAA223344));
      run_xfers(q);

      // Out-of-range write, misaligned half, bad size, IDLE/BUSY must all leave word 0 alone.
      q.push_back(mk(1'b1, 2'b10, 32'h0, 1'b1, 3'b010, 32'h0BADF00D));
      q.push_back(mk(1'b1, 2'b10, 32'h4000, 1'b1, 3'b010, 32'hFFFFFFFF));
      q.push_back(rd_chk(32'h0, 32'h0BADF00D));
      q.push_back(mk(1'b1, 2'b10, 32'h1, 1'b1, 3'b001, 32'h12345678));
      q.push_back(mk(1'b1, 2'b10, 32'h0, 1'b1, 3'b011, 32'h12345678));
      q.push_back(mk(1'b1, 2'b00, 32'h0, 1'b1, 3'b010, 32'h12345678));
      q.push_back(mk(1'b1, 2'b01, 32'h0, 1'b1, 3'b010, 32'h12345678));
      q.push_back(mk(1'b0, 2'b10, 32'h0, 1'b1, 3'b010, 32'h12345678));
      q.push_back(rd_chk(32'h0, 32'h0BADF00D));
      run_xfers(q);

      // Reset in the data phase of a write must not commit it.
      q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b1, 3'b010, 32'h5555AAAA));
      q.push_back(rd_chk(32'h20, 32'h5555AAAA));
      run_xfers(q);
      reset_mid_write(32'h20, 32'h5555AAAA);

      // Random traffic over a small window plus occasional out-of-range words.
      for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 2'b10, 32'(i * 4), 1'b1, 3'b010, $urandom()));
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         t.sel   = ($urandom_range(0, 9) != 0);
         t.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
         word    = $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) word = DEPTH + $urandom_range(0, 15);
         r = $urandom_range(0, 9);
         t.size  = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
         lane    = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) begin
            if (t.size == 3'b001) lane = lane & 2;
            if (t.size == 3'b010) lane = 0;
         end
         t.addr  = 32'(word * 4 + lane);
         t.write = 1'($urandom_range(0, 1));
         t.wdata = $urandom();
         t.chk   = 1'b0;
         t.exp   = '0;
         q.push_back(t);
      end
      run_xfers(q);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
